// File: rtl/uart_frame_rx.sv
// uart_frame_rx: samples an 8N1 serial line and assembles NBYTES bytes (first byte in LSBs) into one frame word.
// Optional build macro UART_RX_PARITY_EN switches to 8E1 reception with an even parity check per byte.
module uart_frame_rx #(
    parameter int BAUD_DIV     = 5208,
    parameter int NBYTES       = 5,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                uart_rx,
    output logic [NBYTES*8-1:0] frame,
    output logic                frame_valid,
    output logic                frame_err,
    output logic                busy
);
    // frame_valid and frame_err are valid-only strobes with no ready: each is high
    // for exactly one cycle and the consumer must capture frame on the valid pulse.
    localparam int BCW = $clog2(BAUD_DIV);
    localparam int TOW = $clog2(TIMEOUT_BITS * BAUD_DIV + 1);
    localparam int BYW = $clog2(NBYTES) + 1;
    localparam logic [BCW-1:0] HALF_M1   = BCW'(BAUD_DIV / 2 - 1);
    localparam logic [BCW-1:0] FULL_M1   = BCW'(BAUD_DIV - 1);
    localparam logic [TOW-1:0] TO_M1     = TOW'(TIMEOUT_BITS * BAUD_DIV - 1);
    localparam logic [BYW-1:0] LAST_LANE = BYW'(NBYTES - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_q;
    state_t              state_d;
    logic                rx_meta;
    logic                rx_sync;
    logic                rx_sync_d;
    logic                rx_fall;
    logic                armed_q;
    logic                sample;
    logic [BCW-1:0]      baud_cnt_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          shift_q;
    logic [BYW-1:0]      byte_cnt_q;
    logic [TOW-1:0]      to_cnt_q;
    logic [NBYTES*8-1:0] asm_q;
    logic                done_q;
    logic                par_ok;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
        end else begin
            rx_meta   <= uart_rx;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
        end
    end

    assign rx_fall = rx_sync_d & ~rx_sync;
    assign busy    = (state_q != IDLE);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // sample marks the cycle on which the current bit (or start glitch check) is taken
    always_comb begin
        state_d = state_q;
        sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && rx_fall) state_d = START;
            end
            START: begin
                if (baud_cnt_q == HALF_M1) begin
                    sample  = 1'b1;
                    state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt_q == FULL_M1) begin
                    sample = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
                    if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt_q == FULL_M1) begin
                    sample  = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt_q == FULL_M1) begin
                    sample  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)                              par_q <= 1'b0;
        else if (state_q == PARITY && sample) par_q <= rx_sync;
    end

    assign par_ok = ~(^{shift_q, par_q});
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            armed_q     <= 1'b0;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            asm_q       <= '0;
            done_q      <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            done_q      <= 1'b0;

            // a fresh start edge only counts once the line has been seen idle-high in IDLE
            if (state_q != IDLE) armed_q <= 1'b0;
            else if (rx_sync)    armed_q <= 1'b1;

            if (state_q == IDLE || sample) baud_cnt_q <= '0;
            else                           baud_cnt_q <= baud_cnt_q + 1'b1;

            if (state_q != DATA) bit_cnt_q <= '0;
            else if (sample)     bit_cnt_q <= bit_cnt_q + 1'b1;

            if (state_q == DATA && sample) shift_q <= {rx_sync, shift_q[7:1]};

            if (state_q == STOP && sample) begin
                if (rx_sync && par_ok) begin
                    asm_q[int'(byte_cnt_q)*8 +: 8] <= shift_q;
                    if (byte_cnt_q == LAST_LANE) begin
                        byte_cnt_q <= '0;
                        done_q     <= 1'b1;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end else begin
                    frame_err  <= 1'b1;
                    byte_cnt_q <= '0;
                    asm_q      <= '0;
                end
            end

            if (done_q) begin
                frame       <= asm_q;
                frame_valid <= 1'b1;
            end

            // inter-byte gap watchdog; a start edge on the expiry cycle still begins lane 0
            if (state_q != IDLE || byte_cnt_q == '0) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_M1) begin
                to_cnt_q   <= '0;
                frame_err  <= 1'b1;
                byte_cnt_q <= '0;
                asm_q      <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

endmodule
